// File: rtl/branch_update_unit.sv
// rtl/branch_update_unit.sv - branch resolution compare, fetch redirect and predictor update FIFO
// Optional feature macro: BRANCH_UPDATE_STATS_EN (adds stat_branches / stat_mispredicts counters)
module branch_update_unit #(
  parameter int DEPTH = 4,
  parameter int BHR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_pc,
  input  logic [1:0]        res_type,
  input  logic              res_cond,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  input  logic              res_pred_taken,
  input  logic [31:0]       res_pred_target,
  input  logic [BHR_W-1:0]  res_bhr,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [31:0]       upd_pc,
  output logic [31:0]       upd_target,
  output logic [31:0]       upd_ret_addr,
  output logic [1:0]        upd_type,
  output logic              upd_branch_en,
  output logic              upd_taken,
  output logic [BHR_W-1:0]  upd_bhr,
  output logic              upd_mispredict
`ifdef BRANCH_UPDATE_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      target;
    logic [1:0]       br_type;
    logic             branch_en;
    logic             taken;
    logic [BHR_W-1:0] bhr;
    logic             mispredict;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      in_entry;
  entry_t      head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        eff_taken;
  logic        mispredict;
  logic [31:0] corrected_pc;

  // Resolve the branch: unconditional kinds are always taken; compare against the prediction
  always_comb begin
    eff_taken    = res_cond ? res_taken : 1'b1;
    mispredict   = (eff_taken != res_pred_taken) ||
                   (eff_taken && (res_target != res_pred_target));
    corrected_pc = eff_taken ? res_target : (res_pc + 32'd4);
    in_entry.pc         = res_pc;
    in_entry.target     = res_target;
    in_entry.br_type    = res_type;
    in_entry.branch_en  = res_cond;
    in_entry.taken      = eff_taken;
    in_entry.bhr        = res_bhr;
    in_entry.mispredict = mispredict;
  end

  // FIFO status and handshakes; a full FIFO refuses the push even when popping this cycle
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    res_ready = !full;
    push      = res_valid && !full;
    pop       = !empty && upd_ready;
  end

  // Pointer register; reset empties the queue immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage; contents are only observable through the empty-gated head below
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  // Head presentation: zeroed while empty so no stale or partial entry is ever shown
  always_comb begin
    head           = empty ? '0 : mem[rd_ptr[AW-1:0]];
    upd_valid      = !empty;
    upd_pc         = head.pc;
    upd_target     = head.target;
    upd_ret_addr   = empty ? 32'd0 : (head.pc + 32'd4);
    upd_type       = head.br_type;
    upd_branch_en  = head.branch_en;
    upd_taken      = head.taken;
    upd_bhr        = head.bhr;
    upd_mispredict = head.mispredict;
  end

  // One-cycle redirect pulse; the pc holds its last value between redirects
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= push && mispredict;
      if (push && mispredict) redirect_pc <= corrected_pc;
    end
  end

`ifdef BRANCH_UPDATE_STATS_EN
  // Saturating resolution and mispredict counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (push && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (push && mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// tb/tb_branch_update_unit.sv - randomized self-checking bench for branch_update_unit
module tb_branch_update_unit;
  localparam int DEPTH = 4;
  localparam int BHR_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_pc;
  logic [1:0]       res_type;
  logic             res_cond;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_pred_taken;
  logic [31:0]      res_pred_target;
  logic [BHR_W-1:0] res_bhr;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic [31:0]      upd_ret_addr;
  logic [1:0]       upd_type;
  logic             upd_branch_en;
  logic             upd_taken;
  logic [BHR_W-1:0] upd_bhr;
  logic             upd_mispredict;
`ifdef BRANCH_UPDATE_STATS_EN
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispredicts;
`endif

  branch_update_unit #(.DEPTH(DEPTH), .BHR_W(BHR_W)) dut (
    .clk(clk), .resetn(resetn),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_type(res_type),
    .res_cond(res_cond), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target), .res_bhr(res_bhr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_ret_addr(upd_ret_addr), .upd_type(upd_type), .upd_branch_en(upd_branch_en),
    .upd_taken(upd_taken), .upd_bhr(upd_bhr), .upd_mispredict(upd_mispredict)
`ifdef BRANCH_UPDATE_STATS_EN
    ,
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      target;
    logic [31:0]      ret;
    logic [1:0]       br_type;
    logic             branch_en;
    logic             taken;
    logic [BHR_W-1:0] bhr;
    logic             mis;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_rv;
  logic [31:0] exp_rpc;
  logic [31:0] exp_sb;
  logic [31:0] exp_sm;
  logic        last_acc;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [104:0] pack_exp(exp_t e);
    return {e.pc, e.target, e.ret, e.br_type, e.branch_en, e.taken, e.bhr, e.mis};
  endfunction

  function automatic logic [104:0] dut_head();
    return {upd_pc, upd_target, upd_ret_addr, upd_type, upd_branch_en, upd_taken, upd_bhr, upd_mispredict};
  endfunction

  // Reference: what a resolution means, straight from the branch rules
  task automatic model_resolve(output exp_t e, output logic [31:0] cpc);
    logic tk;
    tk = res_cond ? res_taken : 1'b1;
    e.pc = res_pc;
    e.target = res_target;
    e.ret = res_pc + 32'd4;
    e.br_type = res_type;
    e.branch_en = res_cond;
    e.taken = tk;
    e.bhr = res_bhr;
    e.mis = (tk != res_pred_taken) || (tk && (res_target != res_pred_target));
    cpc = tk ? res_target : res_pc + 32'd4;
  endtask

  // Advance one clock and update the reference queue/redirect/stats
  task automatic tick();
    exp_t e;
    exp_t dummy;
    logic [31:0] cpc;
    logic acc;
    logic pop;
    acc = res_valid && (exp_q.size() < DEPTH);
    pop = (exp_q.size() > 0) && upd_ready;
    model_resolve(e, cpc);
    @(posedge clk);
    #1;
    if (pop) dummy = exp_q.pop_front();
    exp_rv = 1'b0;
    if (acc) begin
      exp_q.push_back(e);
      if (exp_sb != 32'hFFFF_FFFF) exp_sb = exp_sb + 32'd1;
      if (e.mis) begin
        exp_rv = 1'b1;
        exp_rpc = cpc;
        if (exp_sm != 32'hFFFF_FFFF) exp_sm = exp_sm + 32'd1;
      end
    end
    last_acc = acc;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [1:0] ty, input logic cond,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic [BHR_W-1:0] bhr);
    res_valid = 1'b1; res_pc = pc; res_type = ty; res_cond = cond; res_taken = tk;
    res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt; res_bhr = bhr;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rv = 1'b0; exp_rpc = 32'd0; exp_sb = 32'd0; exp_sm = 32'd0; last_acc = 1'b0;
  endtask

  task automatic drain();
    res_valid = 1'b0;
    upd_ready = 1'b1;
    for (int i = 0; i < 2*DEPTH && exp_q.size() > 0; i++) tick();
    upd_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; res_valid = 1'b0; upd_ready = 1'b0;
    set_res(32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, '0);
    res_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    vectors++;
    if (dut_head() !== 105'd0) begin
      miscompares++; $display("FAIL reset_upd_fields: got %h want 0", dut_head());
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({res_ready, upd_valid, redirect_valid, redirect_pc} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: ready/upd_valid/rv/rpc got %b%b%b %h want 100 0",
                 i, res_ready, upd_valid, redirect_valid, redirect_pc);
      end
    end
  endtask

  task automatic test_mispredict();
    set_res(32'h100, 2'b00, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, 4'h5);
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h200}) begin
      miscompares++; $display("FAIL mispredict_redirect: got %b %h want 1 00000200", redirect_valid, redirect_pc);
    end
    vectors++;
    if ({upd_valid, upd_mispredict, upd_branch_en, upd_pc} !== {3'b111, 32'h100}) begin
      miscompares++;
      $display("FAIL mispredict_update: valid/mis/br_en/pc got %b%b%b %h want 111 00000100",
               upd_valid, upd_mispredict, upd_branch_en, upd_pc);
    end
    tick();
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b0, 32'h200}) begin
      miscompares++; $display("FAIL redirect_one_cycle: got %b %h want 0 00000200", redirect_valid, redirect_pc);
    end
    drain();
    vectors++;
    if (upd_valid !== 1'b0) begin
      miscompares++; $display("FAIL mispredict_drain: upd_valid got %b want 0", upd_valid);
    end
  endtask

  task automatic test_wrap();
    set_res(32'hFFFF_FFFC, 2'b00, 1'b1, 1'b0, 32'h1234, 1'b1, 32'h1234, 4'h3);
    tick();
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL wrap_redirect: got %b %h want 1 00000000", redirect_valid, redirect_pc);
    end
    upd_ready = 1'b1;
    set_res(32'h300, 2'b00, 1'b1, 1'b1, 32'h380, 1'b1, 32'h380, 4'h1);
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({redirect_valid, upd_valid, upd_mispredict, upd_pc} !== {3'b010, 32'h300}) begin
      miscompares++;
      $display("FAIL correct_pred: rv/valid/mis/pc got %b%b%b %h want 010 00000300",
               redirect_valid, upd_valid, upd_mispredict, upd_pc);
    end
    drain();
  endtask

  task automatic test_full();
    int pops;
    upd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_res(32'h1000 + 32'(i*16), 2'b00, 1'b1, 1'b1, 32'h5000, 1'b1, 32'h5000, 4'(i));
      tick();
      vectors++;
      if (res_ready !== (i < DEPTH-1)) begin
        miscompares++; $display("FAIL full_ready push%0d: got %b want %b", i, res_ready, (i < DEPTH-1));
      end
    end
    set_res(32'h2000, 2'b00, 1'b1, 1'b1, 32'h2400, 1'b0, 32'h2400, 4'hA);
    tick();
    vectors++;
    if ({redirect_valid, res_ready, upd_pc} !== {2'b00, 32'h1000}) begin
      miscompares++;
      $display("FAIL full_refuse: rv/ready/head got %b%b %h want 00 00001000", redirect_valid, res_ready, upd_pc);
    end
    upd_ready = 1'b1;
    tick();
    vectors++;
    if ({redirect_valid, res_ready, upd_pc} !== {2'b01, 32'h1010}) begin
      miscompares++;
      $display("FAIL full_pop_no_push: rv/ready/head got %b%b %h want 01 00001010", redirect_valid, res_ready, upd_pc);
    end
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h2400}) begin
      miscompares++; $display("FAIL held_accept: got %b %h want 1 00002400", redirect_valid, redirect_pc);
    end
    pops = 0;
    for (int i = 0; i < 2*DEPTH && upd_valid === 1'b1; i++) begin
      vectors++;
      if (exp_q.size() == 0 || dut_head() !== pack_exp(exp_q[0])) begin
        miscompares++; $display("FAIL drain_order pop%0d: got %h want %h", i, dut_head(),
                                exp_q.size() ? pack_exp(exp_q[0]) : 105'd0);
      end
      tick();
      pops++;
    end
    vectors++;
    if (pops !== 3) begin
      miscompares++; $display("FAIL drain_count: got %0d want 3", pops);
    end
    upd_ready = 1'b0;
  endtask

  task automatic test_call_simul();
    int pops;
    upd_ready = 1'b0;
    set_res(32'h400, 2'b01, 1'b0, 1'b0, 32'h800, 1'b1, 32'h800, 4'h2);
    tick();
    vectors++;
    if ({upd_type, upd_ret_addr, upd_branch_en, upd_taken, redirect_valid} !== {2'b01, 32'h404, 3'b010}) begin
      miscompares++;
      $display("FAIL call_fields: type/ret/br_en/taken/rv got %b %h %b%b%b want 01 00000404 010",
               upd_type, upd_ret_addr, upd_branch_en, upd_taken, redirect_valid);
    end
    set_res(32'h410, 2'b10, 1'b0, 1'b1, 32'h404, 1'b1, 32'h404, 4'h4);
    tick();
    set_res(32'h420, 2'b11, 1'b0, 1'b1, 32'h900, 1'b1, 32'h908, 4'h6);
    upd_ready = 1'b1;
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({redirect_valid, redirect_pc, upd_pc} !== {1'b1, 32'h900, 32'h410}) begin
      miscompares++;
      $display("FAIL simul_push_pop: rv/rpc/head got %b %h %h want 1 00000900 00000410",
               redirect_valid, redirect_pc, upd_pc);
    end
    pops = 0;
    for (int i = 0; i < 2*DEPTH && upd_valid === 1'b1; i++) begin
      vectors++;
      if (exp_q.size() == 0 || dut_head() !== pack_exp(exp_q[0])) begin
        miscompares++; $display("FAIL simul_head pop%0d: got %h", i, dut_head());
      end
      tick();
      pops++;
    end
    vectors++;
    if (pops !== 2) begin
      miscompares++; $display("FAIL simul_occupancy: got %0d want 2", pops);
    end
    upd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    upd_ready = 1'b1;
    set_res(32'h600, 2'b00, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 4'h1);
    tick();
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h700}) begin
      miscompares++; $display("FAIL b2b_first: got %b %h want 1 00000700", redirect_valid, redirect_pc);
    end
    set_res(32'h700, 2'b00, 1'b1, 1'b0, 32'h780, 1'b1, 32'h780, 4'h2);
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h704}) begin
      miscompares++; $display("FAIL b2b_second: got %b %h want 1 00000704", redirect_valid, redirect_pc);
    end
    tick();
    vectors++;
    if (redirect_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_clear: got %b want 0", redirect_valid);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    res_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!res_valid || last_acc) begin
        tgt = $urandom & 32'hFFFF_FFFC;
        set_res($urandom & 32'hFFFF_FFFC, 2'($urandom), 1'($urandom), 1'($urandom), tgt,
                1'($urandom), ($urandom_range(0, 3) != 0) ? tgt : ($urandom & 32'hFFFF_FFFC), 4'($urandom));
        res_valid = ($urandom_range(0, 3) != 0);
      end
      upd_ready = ($urandom_range(0, 2) == 0);
      tick();
      vectors++;
      if ({res_ready, upd_valid} !== {(exp_q.size() < DEPTH), (exp_q.size() > 0)}) begin
        miscompares++; $display("FAIL rand_status cyc%0d: ready/valid got %b%b want %b%b", i, res_ready, upd_valid,
                                (exp_q.size() < DEPTH), (exp_q.size() > 0));
      end
      vectors++;
      if ({redirect_valid, redirect_pc} !== {exp_rv, exp_rpc}) begin
        miscompares++; $display("FAIL rand_redirect cyc%0d: got %b %h want %b %h", i, redirect_valid, redirect_pc,
                                exp_rv, exp_rpc);
      end
      if (exp_q.size() > 0) begin
        vectors++;
        if (dut_head() !== pack_exp(exp_q[0])) begin
          miscompares++; $display("FAIL rand_head cyc%0d: got %h want %h", i, dut_head(), pack_exp(exp_q[0]));
        end
      end
`ifdef BRANCH_UPDATE_STATS_EN
      vectors++;
      if ({stat_branches, stat_mispredicts} !== {exp_sb, exp_sm}) begin
        miscompares++; $display("FAIL rand_stats cyc%0d: got %0d %0d want %0d %0d", i, stat_branches,
                                stat_mispredicts, exp_sb, exp_sm);
      end
`endif
    end
    drain();
  endtask

  task automatic test_reset_mid();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_res(32'h800 + 32'(i*4), 2'b00, 1'b1, 1'b1, 32'hC00, 1'b0, 32'hC00, 4'(i));
      tick();
    end
    res_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({upd_valid, res_ready, redirect_valid, redirect_pc} !== {3'b010, 32'd0}) begin
      miscompares++; $display("FAIL async_reset: valid/ready/rv/rpc got %b%b%b %h want 010 0",
                              upd_valid, res_ready, redirect_valid, redirect_pc);
    end
    vectors++;
    if (dut_head() !== 105'd0) begin
      miscompares++; $display("FAIL async_reset_fields: got %h want 0", dut_head());
    end
`ifdef BRANCH_UPDATE_STATS_EN
    vectors++;
    if ({stat_branches, stat_mispredicts} !== 64'd0) begin
      miscompares++; $display("FAIL stats_reset: got %0d %0d want 0 0", stat_branches, stat_mispredicts);
    end
`endif
    @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    vectors++;
    if (upd_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_empty: upd_valid got %b want 0", upd_valid);
    end
    set_res(32'hA00, 2'b00, 1'b1, 1'b0, 32'hB00, 1'b0, 32'hB00, 4'h7);
    tick();
    res_valid = 1'b0;
    vectors++;
    if ({upd_valid, upd_pc, redirect_valid} !== {1'b1, 32'hA00, 1'b0}) begin
      miscompares++; $display("FAIL post_reset_push: valid/pc/rv got %b %h %b want 1 00000a00 0",
                              upd_valid, upd_pc, redirect_valid);
    end
`ifdef BRANCH_UPDATE_STATS_EN
    vectors++;
    if (stat_branches !== 32'd1) begin
      miscompares++; $display("FAIL stats_count: got %0d want 1", stat_branches);
    end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_wrap();
    test_full();
    test_call_simul();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_update_unit.md
# branch_update_unit

Resolution-side counterpart to the front-end branch predictor. It accepts one resolved branch/jump per cycle from the execute stage and compares the actual outcome with the prediction carried down the pipe. On a mispredict it issues a one-cycle redirect to fetch. Every resolved branch is queued in a small FIFO that drains, under a valid/ready handshake, into the predictor's update ports (history table, BTB, RAS, target cache).

## Interface
- DEPTH, 4, update FIFO entries; power of two, ≥ 2
- BHR_W, 4, branch-history width carried with each branch
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- res_valid  in  1  resolved branch present
- res_ready  out  1  unit can accept; equals !fifo_full
- res_pc  in  32  branch PC
- res_type  in  2  00 direct (cond/jal), 01 call, 10 return, 11 indirect (jalr)
- res_cond  in  1  conditional branch (beq..bgeu)
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- res_pred_taken  in  1  predicted direction
- res_pred_target  in  32  predicted target
- res_bhr  in  BHR_W  history snapshot used at prediction
- redirect_valid  out  1  one-cycle fetch redirect / flush
- redirect_pc  out  32  corrected fetch PC
- upd_valid  out  1  head-of-FIFO update present
- upd_ready  in  1  predictor consumes update
- upd_pc, upd_target  out  32  branch PC, actual target
- upd_ret_addr  out  32  upd_pc + 4 (RAS push value for calls)
- upd_type  out  2  copy of res_type
- upd_branch_en  out  1  entry is conditional (history/counter update)
- upd_taken  out  1  actual direction
- upd_bhr  out  BHR_W  history snapshot
- upd_mispredict  out  1  entry was mispredicted

## Operation
- Accept: res_valid && res_ready at an edge.
- mispredict = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target).
- Direct/unconditional types (res_cond=0) are treated as taken regardless of res_taken.
- Corrected PC: res_target if taken, else res_pc + 4, mod 2^32 (wraps; no carry out).
- On an accepted mispredict: redirect_valid=1 and redirect_pc=corrected PC, registered, for exactly one cycle. Otherwise redirect_valid=0 and redirect_pc holds its last value.
- Each accepted resolution, mispredicted or not, is pushed into the FIFO.
- FIFO: circular buffer with wr/rd pointers of log2(DEPTH)+1 bits.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
- upd_* fields show the head entry. upd_valid = !empty.
- Pop on upd_valid && upd_ready.
- Full: res_ready=0. No write-through to a popping slot; a push is refused even if a pop occurs in the same cycle.
- Empty: upd_valid=0. Pushed data is not bypassed to upd_* in the push cycle.
- Simultaneous push and pop when neither full nor empty: both occur, occupancy unchanged.
- Unaccepted res_valid (res_ready=0) produces no redirect and no push. Execute must hold its inputs stable until accepted.

## Timing
- Reset (resetn low, asynchronous):
  - FIFO empty, pointers 0.
  - redirect_valid=0, redirect_pc=0.
  - upd_valid=0, all upd_* fields 0.
  - res_ready=1.
- Resolution accepted at edge N → redirect (if any) visible in cycle N..N+1 and cleared at edge N+1.
- The same resolution is visible as upd_valid in cycle N..N+1 if the FIFO was empty. Push-to-head latency is 1 cycle.
- Back-to-back mispredicts on consecutive edges give redirect_valid high for two consecutive cycles, each with its own pc.
- Reset asserted mid-operation discards all queued updates immediately. No partial update is presented after reset release.

## Configuration
- BRANCH_UPDATE_STATS_EN defined: adds two 32-bit saturating counters.
  - stat_branches counts accepted resolutions.
  - stat_mispredicts counts accepted mispredicts.
  - Both saturate at 32'hFFFFFFFF, reset to 0, and are exposed as output ports of the same names.
- BRANCH_UPDATE_STATS_EN undefined: counters and ports are absent. All other behaviour is identical.

## Test plan
- Reset release, no traffic → res_ready=1, upd_valid=0, redirect_valid=0 for 10 cycles.
- Cond branch pc=0x100, taken=1, target=0x200, pred_taken=0 → next cycle redirect_valid=1, redirect_pc=0x200. upd_valid=1, upd_mispredict=1, upd_branch_en=1.
- Cond branch pc=0xFFFFFFFC, taken=0, pred_taken=1 → redirect_pc=0x00000000 (wrap). Correct prediction with matching target → no redirect, upd_mispredict=0.
- upd_ready=0, push 4 resolutions (DEPTH=4) → res_ready=0 after the 4th; a 5th held request is not accepted. Raise upd_ready → entries drain in order, res_ready=1 after the first pop.
- Call at pc=0x400 → upd_type=01, upd_ret_addr=0x404. With the FIFO at 2 entries, simultaneous push and pop leaves occupancy at 2.
- Assert resetn low with 3 queued entries → upd_valid=0 asynchronously. With BRANCH_UPDATE_STATS_EN, stat_branches=0 after reset and increments per accepted resolution.
